// File: rtl/mem_wb_stage.sv
// LEGv8 memory-access stage: branch resolve, handshaked data-memory port,
// MEM/WB pipeline register and stall counter. Optional MEM_ALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] Add_result,
  input  logic [DATA_W-1:0] Alu_result,
  input  logic              Zero,
  input  logic [DATA_W-1:0] Read2,
  input  logic [REG_W-1:0]  Write_reg,
  input  logic              Branch,
  input  logic              UncBranch,
  input  logic              Memread,
  input  logic              Memwrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [CNT_W-1:0]  stall_count,
  output logic              misalign_err,
  output logic              dbg_state
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Handshake: dmem_req rises with addr/wdata/we and all four hold steady
  // until the first edge where dmem_ready=1; that edge completes the access.
  state_t state;
  logic   memop;
  logic   misalign;
  logic   retire;

  assign memop = in_valid & (Memread | Memwrite);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (state == IDLE) & memop & (Alu_result[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  assign misalign_err  = misalign;
  assign stall         = ((state == IDLE) & memop & ~misalign) |
                         ((state == WAIT) & ~dmem_ready);
  // The EX/MEM entry moves into MEM/WB on any edge where it is not held back
  // and was not rejected for misalignment.
  assign retire        = ~stall & ~misalign;
  assign pc_src        = in_valid & (UncBranch | (Branch & Zero));
  assign branch_target = Add_result;
  assign dbg_state     = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg   <= 1'b0;
      wb_write_reg  <= '0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      stall_count   <= '0;
    end else begin
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};

      case (state)
        IDLE: begin
          if (memop && !misalign) begin
            state      <= WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= Memwrite;
            dmem_addr  <= Alu_result;
            dmem_wdata <= Read2;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            if (!dmem_we)
              wb_read_data <= dmem_rdata;
          end
        end
        default: state <= IDLE;
      endcase

      if (retire) begin
        wb_valid      <= in_valid;
        wb_regwrite   <= RegWrite & in_valid;
        wb_memtoreg   <= MemtoReg;
        wb_write_reg  <= Write_reg;
        wb_alu_result <= Alu_result;
      end else begin
        wb_valid    <= 1'b0;
        wb_regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: transaction-level model checked every
// negedge plus hand-computed literal expectations.
module tb_mem_wb_stage;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, Zero, Branch, UncBranch, Memread, Memwrite, RegWrite, MemtoReg;
  logic [DW-1:0] Add_result, Alu_result, Read2, dmem_rdata;
  logic [RW-1:0] Write_reg;
  logic          dmem_ready;
  logic          dmem_req, dmem_we, stall, pc_src, misalign_err, dbg_state;
  logic [DW-1:0] dmem_addr, dmem_wdata, branch_target, wb_read_data, wb_alu_result;
  logic          wb_valid, wb_regwrite, wb_memtoreg;
  logic [RW-1:0] wb_write_reg;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .Add_result(Add_result),
    .Alu_result(Alu_result), .Zero(Zero), .Read2(Read2), .Write_reg(Write_reg),
    .Branch(Branch), .UncBranch(UncBranch), .Memread(Memread), .Memwrite(Memwrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_write_reg(wb_write_reg), .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .stall_count(stall_count), .misalign_err(misalign_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // m_pend: an access has been issued to memory and not yet acknowledged.
  logic          m_pend = 1'b0;
  logic          m_we = 1'b0;
  logic [DW-1:0] m_addr = '0, m_wdata = '0;
  logic          m_valid = 1'b0, m_rw = 1'b0, m_m2r = 1'b0;
  logic [RW-1:0] m_wreg = '0;
  logic [DW-1:0] m_rd = '0, m_alu = '0;
  int            m_cnt = 0;

  function automatic logic f_memop();
    return in_valid & (Memread | Memwrite);
  endfunction

  function automatic logic f_mis();
`ifdef MEM_ALIGN_CHECK_EN
    return !m_pend && f_memop() && (Alu_result[2:0] != 3'b000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic f_stall();
    if (m_pend) return !dmem_ready;
    return f_memop() && !f_mis();
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pend <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_valid <= 1'b0; m_rw <= 1'b0; m_m2r <= 1'b0; m_wreg <= '0;
      m_rd <= '0; m_alu <= '0; m_cnt <= 0;
    end else begin
      if (f_stall()) m_cnt <= (m_cnt >= (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
      if (!m_pend && f_memop() && !f_mis()) begin
        m_pend <= 1'b1; m_we <= Memwrite; m_addr <= Alu_result; m_wdata <= Read2;
      end else if (m_pend && dmem_ready) begin
        m_pend <= 1'b0;
        if (Memread && !Memwrite) m_rd <= dmem_rdata;
      end
      if (f_stall() || f_mis()) begin
        m_valid <= 1'b0; m_rw <= 1'b0;
      end else begin
        m_valid <= in_valid; m_rw <= RegWrite & in_valid; m_m2r <= MemtoReg;
        m_wreg <= Write_reg; m_alu <= Alu_result;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    chk("stall", stall, f_stall());
    chk("pc_src", pc_src, in_valid & (UncBranch | (Branch & Zero)));
    chk("branch_target", branch_target, Add_result);
    chk("misalign_err", misalign_err, f_mis());
    chk("dmem_req", dmem_req, m_pend);
    if (m_pend) begin
      chk("dmem_addr", dmem_addr, m_addr);
      chk("dmem_wdata", dmem_wdata, m_wdata);
      chk("dmem_we", dmem_we, m_we);
    end
    chk("wb_valid", wb_valid, m_valid);
    chk("wb_regwrite", wb_regwrite, m_rw);
    chk("wb_memtoreg", wb_memtoreg, m_m2r);
    chk("wb_write_reg", wb_write_reg, m_wreg);
    chk("wb_read_data", wb_read_data, m_rd);
    chk("wb_alu_result", wb_alu_result, m_alu);
    chk("stall_count", stall_count, m_cnt);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 0; Branch = 0; UncBranch = 0; Zero = 0; Memread = 0; Memwrite = 0;
    RegWrite = 0; MemtoReg = 0; Write_reg = '0; Alu_result = '0; Read2 = '0;
    Add_result = '0; dmem_ready = 0; dmem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_entry(input logic v, br, ub, z, mr, mw, rw, m2r,
                           input logic [RW-1:0] wreg, input logic [DW-1:0] alu, rd2, add);
    in_valid = v; Branch = br; UncBranch = ub; Zero = z; Memread = mr; Memwrite = mw;
    RegWrite = rw; MemtoReg = m2r; Write_reg = wreg; Alu_result = alu; Read2 = rd2;
    Add_result = add;
  endtask

  // Holds a memory op in EX/MEM; memory answers in the k-th cycle after entry.
  task automatic mem_op(input logic rd, wr, rw, m2r, input logic [RW-1:0] wreg,
                        input logic [DW-1:0] addr, data, rdata, input int k,
                        output int reqc, output int stallc, output logic [DW-1:0] a_seen,
                        output logic [DW-1:0] w_seen, output logic we_seen);
    reqc = 0; stallc = 0; a_seen = '0; w_seen = '0; we_seen = 0;
    set_entry(1, 0, 0, 0, rd, wr, rw, m2r, wreg, addr, data, '0);
    for (int c = 0; c <= k; c++) begin
      dmem_ready = (c == k);
      dmem_rdata = (c == k) ? rdata : '0;
      @(negedge clock);
      if (stall) stallc++;
      if (dmem_req) begin
        reqc++; a_seen = dmem_addr; w_seen = dmem_wdata; we_seen = dmem_we;
      end
      step();
    end
    idle_inputs();
  endtask

  // ---------------- directed sequence ----------------
  int            reqc, stallc;
  logic [DW-1:0] a_seen, w_seen;
  logic          we_seen;

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    reset = 0;

    // ALU op
    set_entry(1, 0, 0, 0, 0, 0, 1, 0, 5'd3, 64'h2A, '0, '0);
    #1 chk("alu_stall", stall, 0);
    step();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_regwrite", wb_regwrite, 1);
    chk("alu_wb_write_reg", wb_write_reg, 3);
    chk("alu_wb_alu_result", wb_alu_result, 64'h2A);
    // bubble with RegWrite set must not write
    set_entry(0, 0, 0, 0, 0, 0, 1, 0, 5'd4, 64'h77, '0, '0);
    step();
    chk("bubble_wb_regwrite", wb_regwrite, 0);

    // branches
    set_entry(1, 1, 0, 1, 0, 0, 0, 0, '0, '0, '0, 64'h100);
    #1 chk("cbz_taken", pc_src, 1);
    chk("cbz_target", branch_target, 64'h100);
    Zero = 0;
    #1 chk("cbz_not_taken", pc_src, 0);
    UncBranch = 1;
    #1 chk("unc_taken", pc_src, 1);
    in_valid = 0;
    #1 chk("unc_bubble", pc_src, 0);
    in_valid = 1;
    step();
    idle_inputs();

    // LDUR x5, [0x40], memory answers in 3rd cycle
    mem_op(1, 0, 1, 1, 5'd5, 64'h40, '0, 64'hDEAD, 3, reqc, stallc, a_seen, w_seen, we_seen);
    chk("ld_req_cycles", reqc, 3);
    chk("ld_stall_cycles", stallc, 3);
    chk("ld_addr", a_seen, 64'h40);
    chk("ld_we", we_seen, 0);
    chk("ld_read_data", wb_read_data, 64'hDEAD);
    chk("ld_memtoreg", wb_memtoreg, 1);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_stall_count", stall_count, 3);

    // STUR 0x1234 -> [0x80], ready on first cycle
    mem_op(0, 1, 0, 0, 5'd0, 64'h80, 64'h1234, 64'hFFFF, 1, reqc, stallc, a_seen, w_seen, we_seen);
    chk("st_req_cycles", reqc, 1);
    chk("st_stall_cycles", stallc, 1);
    chk("st_we", we_seen, 1);
    chk("st_wdata", w_seen, 64'h1234);
    chk("st_regwrite", wb_regwrite, 0);
    chk("st_read_data_held", wb_read_data, 64'hDEAD);

    // Memread+Memwrite together: store, RegWrite still honoured
    mem_op(1, 1, 1, 0, 5'd7, 64'h88, 64'h55, 64'h77, 1, reqc, stallc, a_seen, w_seen, we_seen);
    chk("both_we", we_seen, 1);
    chk("both_regwrite", wb_regwrite, 1);
    chk("both_read_data_held", wb_read_data, 64'hDEAD);
    chk("both_stall_count", stall_count, 5);

    // back-to-back loads; counter saturates at 7
    mem_op(1, 0, 1, 1, 5'd8, 64'h90, '0, 64'h1111, 2, reqc, stallc, a_seen, w_seen, we_seen);
    mem_op(1, 0, 1, 1, 5'd9, 64'h98, '0, 64'h2222, 2, reqc, stallc, a_seen, w_seen, we_seen);
    chk("b2b_stall_cycles", stallc, 2);
    chk("b2b_read_data", wb_read_data, 64'h2222);
    chk("b2b_write_reg", wb_write_reg, 9);
    chk("sat_stall_count", stall_count, 7);

    // ready while idle is ignored
    dmem_ready = 1; dmem_rdata = 64'h3333;
    step();
    chk("idle_ready_req", dmem_req, 0);
    chk("idle_ready_rd", wb_read_data, 64'h2222);
    idle_inputs();

    // misaligned load at 0x43
`ifdef MEM_ALIGN_CHECK_EN
    set_entry(1, 0, 0, 0, 1, 0, 1, 1, 5'd2, 64'h43, '0, '0);
    #1 chk("mis_err", misalign_err, 1);
    chk("mis_stall", stall, 0);
    step();
    idle_inputs();
    #1 chk("mis_err_gone", misalign_err, 0);
    chk("mis_wb_valid", wb_valid, 0);
    chk("mis_no_req", dmem_req, 0);
`else
    mem_op(1, 0, 1, 1, 5'd2, 64'h43, '0, 64'h4444, 1, reqc, stallc, a_seen, w_seen, we_seen);
    chk("mis_addr_pass", a_seen, 64'h43);
    chk("mis_err_tied", misalign_err, 0);
`endif

    // reset during WAIT of a load
    set_entry(1, 0, 0, 0, 1, 0, 1, 1, 5'd6, 64'h48, '0, '0);
    dmem_ready = 0;
    step();
    chk("rw_req_before", dmem_req, 1);
    #2 reset = 1;
    #1 chk("rw_req_dropped", dmem_req, 0);
    chk("rw_wb_valid", wb_valid, 0);
    chk("rw_stall_count", stall_count, 0);
    chk("rw_read_data", wb_read_data, 0);
    idle_inputs();
    step();
    reset = 0;
    dmem_ready = 1; dmem_rdata = 64'hBEEF;
    step();
    step();
    chk("rw_no_writeback", wb_valid, 0);
    chk("rw_no_read_data", wb_read_data, 0);
    chk("rw_no_req", dmem_req, 0);
    idle_inputs();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
